// File: rtl/mem_arbiter_pkg.sv
// Types and helpers shared by the two-port memory arbiter and its bench.
// State encodings come from constants.v so other blocks decode them identically.
`include "constants.v"

package mem_arbiter_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        ST_IDLE      = `MEM_ARB_ST_IDLE,
        ST_ISSUE     = `MEM_ARB_ST_ISSUE,
        ST_WAIT_DATA = `MEM_ARB_ST_WAIT_DATA
    } state_t;

    function automatic logic [NUM_REQ-1:0] id_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/constants.v
// Shared memory-subsystem constants: width defaults, read watchdog default
// and the arbiter FSM state encodings.
`ifndef MEM_ARB_CONSTANTS_V
`define MEM_ARB_CONSTANTS_V

`define DEFAULT_MADDR_WIDTH 16
`define DEFAULT_MDATA_WIDTH 16
`define DEFAULT_MEM_TIMEOUT 1024

`define MEM_ARB_ST_IDLE      2'd0
`define MEM_ARB_ST_ISSUE     2'd1
`define MEM_ARB_ST_WAIT_DATA 2'd2

`endif

// File: rtl/mem_arbiter_rr_select.sv
// Two-way round-robin winner selection: on contention the requester that
// did not win last time is picked; a lone requester always wins.
module rr_select (
    input  logic [1:0] req_valid,
    input  logic       last_grant,
    output logic       grant_id,
    output logic       any_valid
);

    always_comb begin
        any_valid = |req_valid;
        grant_id  = 1'b0;
        if (&req_valid) begin
            grant_id = ~last_grant;
        end else if (req_valid[1]) begin
            grant_id = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates EdgeCache (id 0) and node table (id 1) onto one memory port,
// one transaction at a time. Optional read watchdog: define MEM_ARB_TIMEOUT_EN.
`include "constants.v"

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MADDR_WIDTH    = `DEFAULT_MADDR_WIDTH,
    parameter int MDATA_WIDTH    = `DEFAULT_MDATA_WIDTH,
    parameter int TIMEOUT_CYCLES = `DEFAULT_MEM_TIMEOUT
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [1:0]               req_valid,
    input  logic [1:0]               req_write,
    input  logic [2*MADDR_WIDTH-1:0] req_addr,
    input  logic [2*MDATA_WIDTH-1:0] req_wdata,
    output logic [1:0]               req_ack,
    output logic [1:0]               rsp_valid,
    output logic [MDATA_WIDTH-1:0]   rsp_data,
    output logic [MADDR_WIDTH-1:0]   mem_addr,
    output logic [MDATA_WIDTH-1:0]   mem_wdata,
    output logic                     mem_read,
    output logic                     mem_write,
    input  logic                     mem_wait_request,
    input  logic [MDATA_WIDTH-1:0]   mem_data,
    input  logic                     mem_read_ready,
    output logic                     busy,
    output logic                     timeout_error,
    output state_t                   dbg_state
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    // Handshakes: a request is taken in IDLE (never in a rsp_valid cycle) and
    // confirmed by a one-cycle req_ack in the first ISSUE cycle; the memory
    // accepts when mem_wait_request is low at a rising edge with a strobe high;
    // read data is taken only in WAIT_DATA on mem_read_ready; completion is a
    // one-cycle rsp_valid[id] pulse.
    state_t                 r_state;
    state_t                 w_next_state;
    logic                   r_last_grant;
    logic                   r_id;
    logic                   r_write;
    logic [MADDR_WIDTH-1:0] r_addr;
    logic [MDATA_WIDTH-1:0] r_wdata;
    logic [1:0]             r_req_ack;
    logic [1:0]             r_rsp_valid;
    logic [MDATA_WIDTH-1:0] r_rsp_data;

    logic                   w_grant_id;
    logic                   w_any_valid;
    logic                   w_latch;
    logic                   w_accept;
    logic                   w_rd_done;
    logic                   w_timeout;
    logic                   w_sel_write;
    logic [MADDR_WIDTH-1:0] w_sel_addr;
    logic [MDATA_WIDTH-1:0] w_sel_wdata;

    rr_select u_rr_select (
        .req_valid  (req_valid),
        .last_grant (r_last_grant),
        .grant_id   (w_grant_id),
        .any_valid  (w_any_valid)
    );

    always_comb begin
        w_sel_write = w_grant_id ? req_write[1] : req_write[0];
        w_sel_addr  = w_grant_id ? req_addr[2*MADDR_WIDTH-1:MADDR_WIDTH]
                                 : req_addr[MADDR_WIDTH-1:0];
        w_sel_wdata = w_grant_id ? req_wdata[2*MDATA_WIDTH-1:MDATA_WIDTH]
                                 : req_wdata[MDATA_WIDTH-1:0];
    end

    // The rsp_valid term forces one idle cycle between transactions.
    assign w_latch   = (r_state == ST_IDLE) && w_any_valid && (r_rsp_valid == 2'b00);
    assign w_accept  = (r_state == ST_ISSUE) && !mem_wait_request;
    assign w_rd_done = (r_state == ST_WAIT_DATA) && mem_read_ready;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_timeout_error;

    assign w_timeout = (r_state == ST_WAIT_DATA) && !mem_read_ready &&
                       (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wait_cnt      <= '0;
            r_timeout_error <= 1'b0;
        end else begin
            if (r_state != ST_WAIT_DATA) begin
                r_wait_cnt <= '0;
            end else if (!mem_read_ready) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_timeout_error <= 1'b1;
            end
        end
    end

    assign timeout_error = r_timeout_error;
`else
    assign w_timeout     = 1'b0;
    assign timeout_error = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_latch) begin
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (w_accept) begin
                    w_next_state = r_write ? ST_IDLE : ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: begin
                if (w_rd_done || w_timeout) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_req_ack    <= '0;
            r_rsp_valid  <= '0;
            r_rsp_data   <= '0;
        end else begin
            r_req_ack   <= '0;
            r_rsp_valid <= '0;
            if (w_latch) begin
                r_id         <= w_grant_id;
                r_last_grant <= w_grant_id;
                r_write      <= w_sel_write;
                r_addr       <= w_sel_addr;
                r_wdata      <= w_sel_wdata;
                r_req_ack    <= id_onehot(w_grant_id);
            end
            if (w_accept && r_write) begin
                r_rsp_valid <= id_onehot(r_id);
            end
            if (w_rd_done) begin
                r_rsp_data  <= mem_data;
                r_rsp_valid <= id_onehot(r_id);
            end
            // A watchdog expiry completes the read with an all-ones poison word.
            if (w_timeout) begin
                r_rsp_data  <= '1;
                r_rsp_valid <= id_onehot(r_id);
            end
        end
    end

    assign req_ack   = r_req_ack;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_read  = (r_state == ST_ISSUE) && !r_write;
    assign mem_write = (r_state == ST_ISSUE) && r_write;
    assign busy      = (r_state != ST_IDLE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter; build with MEM_ARB_TIMEOUT_EN
// defined to also exercise the read watchdog (TIMEOUT_CYCLES = 8).
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TO = 8;
    localparam int RW = 2 + DW;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic [1:0]      req_valid = '0;
    logic [1:0]      req_write = '0;
    logic [2*AW-1:0] req_addr = '0;
    logic [2*DW-1:0] req_wdata = '0;
    logic [1:0]      req_ack;
    logic [1:0]      rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic            mem_read;
    logic            mem_write;
    logic            mem_wait_request = 1'b0;
    logic [DW-1:0]   mem_data = '0;
    logic            mem_read_ready = 1'b0;
    logic            busy;
    logic            timeout_error;
    state_t          dbg_state;

    int checks = 0;
    int errors = 0;
    logic [RW-1:0] exp_q[$];
    logic [1:0]    gnt_q[$];
    logic [DW-1:0] model_rsp_data = '0;
    logic [RW-1:0] mon_e;
    logic [1:0]    mon_g;

    mem_arbiter #(
        .MADDR_WIDTH    (AW),
        .MDATA_WIDTH    (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .req_valid        (req_valid),
        .req_write        (req_write),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .req_ack          (req_ack),
        .rsp_valid        (rsp_valid),
        .rsp_data         (rsp_data),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .mem_wait_request (mem_wait_request),
        .mem_data         (mem_data),
        .mem_read_ready   (mem_read_ready),
        .busy             (busy),
        .timeout_error    (timeout_error),
        .dbg_state        (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "tb_mem_arbiter stalled");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] onehot(input int id);
        return (id == 1) ? 2'b10 : 2'b01;
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clock) begin
        if (reset_n && rsp_valid != 2'b00) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rsp_valid=%b expected none at %0t", rsp_valid, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_valid", 32'(rsp_valid), 32'(mon_e[RW-1:DW]));
                chk("rsp_data", 32'(rsp_data), 32'(mon_e[DW-1:0]));
            end
        end
        if (reset_n && req_ack != 2'b00) begin
            if (gnt_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got req_ack=%b expected none at %0t", req_ack, $time);
            end else begin
                mon_g = gnt_q.pop_front();
                chk("req_ack", 32'(req_ack), 32'(mon_g));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        @(negedge clock);
        reset_n          = 1'b0;
        req_valid        = '0;
        mem_wait_request = 1'b0;
        mem_read_ready   = 1'b0;
        model_rsp_data   = '0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic start_req(input int id, input logic wr, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wd, input int n_wait);
        req_valid[id]              = 1'b1;
        req_write[id]              = wr;
        req_addr[id*AW +: AW]      = addr;
        req_wdata[id*DW +: DW]     = wd;
        mem_wait_request           = (n_wait > 0);
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            n++;
            if (req_ack != 2'b00) break;
        end
        if (req_ack == 2'b00) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: got no req_ack expected one within 20 cycles");
        end
    endtask

    // Called in the first ISSUE cycle; returns at the first cycle after accept.
    task automatic run_issue(input int n_wait, input logic wr,
                             input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        int cnt;
        cnt = 0;
        while ((mem_read || mem_write) && cnt < 64) begin
            cnt++;
            chk("issue_strobe", 32'({mem_read, mem_write}), wr ? 32'h1 : 32'h2);
            chk("issue_addr", 32'(mem_addr), 32'(addr));
            if (wr) chk("issue_wdata", 32'(mem_wdata), 32'(wd));
            chk("issue_busy", 32'(busy), 32'h1);
            if (cnt == n_wait + 1) mem_wait_request = 1'b0;
            @(negedge clock);
        end
        chk("issue_cycles", 32'(cnt), 32'(n_wait + 1));
    endtask

    task automatic finish_read(input int delay, input logic [DW-1:0] data);
        repeat (delay) @(negedge clock);
        mem_read_ready = 1'b1;
        mem_data       = data;
        @(negedge clock);
        mem_read_ready = 1'b0;
        model_rsp_data = data;
    endtask

    task automatic do_write(input int id, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wd, input int n_wait);
        int n;
        gnt_q.push_back(onehot(id));
        exp_q.push_back({onehot(id), model_rsp_data});
        start_req(id, 1'b1, addr, wd, n_wait);
        wait_ack(n);
        req_valid[id] = 1'b0;
        run_issue(n_wait, 1'b1, addr, wd);
        chk("write_done_state", 32'(dbg_state), 32'(ST_IDLE));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        repeat (2) @(negedge clock);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_strobes", 32'({mem_read, mem_write}), 32'h0);
        chk("reset_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("reset_rsp_data", 32'(rsp_data), 32'h0);
        chk("reset_timeout_error", 32'(timeout_error), 32'h0);
        reset_n = 1'b1;
        @(negedge clock);

        // Single read from EdgeCache, data three cycles into WAIT_DATA.
        gnt_q.push_back(2'b01);
        exp_q.push_back({2'b01, 16'hBEEF});
        start_req(0, 1'b0, 16'h0040, 16'h0000, 0);
        wait_ack(n);
        chk("read_req_latency", 32'(n), 32'h1);
        req_valid[0] = 1'b0;
        run_issue(0, 1'b0, 16'h0040, 16'h0000);
        chk("read_wait_state", 32'(dbg_state), 32'(ST_WAIT_DATA));
        finish_read(2, 16'hBEEF);
        @(negedge clock);
        chk("read_idle_after", 32'(busy), 32'h0);

        // Stray read-ready while idle is discarded.
        mem_read_ready = 1'b1;
        mem_data       = 16'h5555;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            chk("stray_rsp_valid", 32'(rsp_valid), 32'h0);
            chk("stray_state", 32'(dbg_state), 32'(ST_IDLE));
            chk("stray_rsp_data", 32'(rsp_data), 32'(model_rsp_data));
        end
        mem_read_ready = 1'b0;

        // Write from node table held off by five wait-request cycles.
        do_write(1, 16'h0123, 16'hCAFE, 5);
        @(negedge clock);

        // Both requesters held: grants alternate starting at 0 after reset.
        apply_reset();
        req_addr         = {16'h0200, 16'h0100};
        req_write        = 2'b00;
        mem_wait_request = 1'b0;
        req_valid        = 2'b11;
        for (int t = 0; t < 4; t++) begin
            gnt_q.push_back(onehot(t % 2));
            exp_q.push_back({onehot(t % 2), 16'hA000 + 16'(t)});
            wait_ack(n);
            if (t > 0) chk("rr_idle_gap", 32'(n), 32'h2);
            chk("rr_addr", 32'(mem_addr), (t % 2 == 1) ? 32'h0200 : 32'h0100);
            @(negedge clock);
            chk("rr_wait_state", 32'(dbg_state), 32'(ST_WAIT_DATA));
            finish_read(0, 16'hA000 + 16'(t));
        end
        req_valid = 2'b00;
        @(negedge clock);

        // Reset in WAIT_DATA abandons the read silently.
        gnt_q.push_back(2'b01);
        start_req(0, 1'b0, 16'h0080, 16'h0000, 0);
        wait_ack(n);
        req_valid[0] = 1'b0;
        run_issue(0, 1'b0, 16'h0080, 16'h0000);
        reset_n = 1'b0;
        #1;
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("rst_outputs", 32'({mem_read, mem_write, req_ack, rsp_valid, busy, timeout_error}), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        chk("rst_rsp_data", 32'(rsp_data), 32'h0);
        model_rsp_data = '0;
        @(negedge clock);
        reset_n        = 1'b1;
        mem_read_ready = 1'b1;
        mem_data       = 16'h1234;
        @(negedge clock);
        mem_read_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("rst_no_rsp", 32'(rsp_valid), 32'h0);
            chk("rst_idle", 32'(dbg_state), 32'(ST_IDLE));
            chk("rst_rsp_data_kept", 32'(rsp_data), 32'h0);
            @(negedge clock);
        end

`ifdef MEM_ARB_TIMEOUT_EN
        // Read with no data: watchdog completes after eight WAIT_DATA cycles.
        gnt_q.push_back(2'b01);
        exp_q.push_back({2'b01, 16'hFFFF});
        start_req(0, 1'b0, 16'h0300, 16'h0000, 0);
        wait_ack(n);
        req_valid[0] = 1'b0;
        run_issue(0, 1'b0, 16'h0300, 16'h0000);
        n = 0;
        while (dbg_state == ST_WAIT_DATA && n < 100) begin
            n++;
            @(negedge clock);
        end
        chk("timeout_wait_cycles", 32'(n), 32'(TO));
        chk("timeout_flag_set", 32'(timeout_error), 32'h1);
        model_rsp_data = 16'hFFFF;
        @(negedge clock);
        do_write(0, 16'h0310, 16'h0F0F, 0);
        @(negedge clock);
        chk("timeout_flag_sticky", 32'(timeout_error), 32'h1);
        apply_reset();
        @(negedge clock);
        chk("timeout_flag_cleared", 32'(timeout_error), 32'h0);
`else
        chk("timeout_flag_tied", 32'(timeout_error), 32'h0);
`endif

        repeat (3) @(negedge clock);
        chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
        chk("gnt_q_drained", 32'(gnt_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MADDR_WIDTH, default `DEFAULT_MADDR_WIDTH, the memory address width.
REQ-002 SHALL have parameter MDATA_WIDTH, default `DEFAULT_MDATA_WIDTH, the memory data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default `DEFAULT_MEM_TIMEOUT (1024), the read response watchdog limit.
REQ-004 SHALL have ports: clock  in  1  single clock, rising edge; reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports: req_valid  in  2  per-requester request (bit 0 = EdgeCache, bit 1 = node table); req_write  in  2  1 = write, 0 = read.
REQ-006 SHALL have ports: req_addr  in  2*MADDR_WIDTH  packed addresses (requester i at slice i); req_wdata  in  2*MDATA_WIDTH  packed write data.
REQ-007 SHALL have ports: req_ack  out  2  one-cycle pulse when the request is latched; rsp_valid  out  2  one-cycle completion pulse; rsp_data  out  MDATA_WIDTH  read data, shared by both requesters.
REQ-008 SHALL have ports: mem_addr  out  MADDR_WIDTH; mem_wdata  out  MDATA_WIDTH; mem_read  out  1; mem_write  out  1; mem_wait_request  in  1; mem_data  in  MDATA_WIDTH; mem_read_ready  in  1.
REQ-009 SHALL have ports: busy  out  1  not IDLE; timeout_error  out  1  sticky watchdog flag.

Function
REQ-010 SHALL implement FSM states IDLE, ISSUE and WAIT_DATA, with at most one outstanding memory transaction.
REQ-011 In IDLE, with any req_valid set at a clock edge, SHALL latch the winner's address, write flag, write data and id, then enter ISSUE.
REQ-012 Arbitration SHALL be round-robin: when both requesters are valid, grant the id != last_grant; when only one is valid, grant it. last_grant updates on every latch.
REQ-013 req_ack[id] SHALL be high exactly during the first ISSUE cycle; the requester SHALL drop or change req_valid at the edge ending that cycle.
REQ-014 In ISSUE, SHALL hold mem_read or mem_write high, with mem_addr and mem_wdata stable, until mem_wait_request is sampled low.
REQ-015 When a write is accepted, SHALL pulse rsp_valid[id] next cycle, leave rsp_data unchanged and return to IDLE.
REQ-016 When a read is accepted, SHALL deassert mem_read next cycle and enter WAIT_DATA.
REQ-017 In WAIT_DATA, on mem_read_ready, SHALL register mem_data into rsp_data, pulse rsp_valid[id] for one cycle and return to IDLE.
REQ-018 SHALL ignore mem_read_ready in IDLE and ISSUE, so stray or post-reset responses are discarded.
REQ-019 Minimum latency SHALL be request-to-mem_read 1 cycle and read accept-to-rsp_valid 1 cycle after mem_read_ready.
REQ-020 SHALL drive all outputs at all times, never 'z'; mem_read and mem_write SHALL never be high together.
REQ-021 A new request SHALL NOT be latched in the cycle rsp_valid pulses; there is one mandatory IDLE cycle between transactions.

Reset
REQ-022 reset_n low SHALL asynchronously force IDLE, last_grant = 1, and outputs mem_read, mem_write, req_ack, rsp_valid, busy, timeout_error = 0 and mem_addr, mem_wdata, rsp_data = 0.
REQ-023 Reset mid-transaction SHALL abandon it without any rsp_valid pulse.

Configuration
REQ-024 With MEM_ARB_TIMEOUT_EN defined, SHALL count WAIT_DATA cycles; on reaching TIMEOUT_CYCLES without mem_read_ready it SHALL pulse rsp_valid[id] with rsp_data all-ones, set timeout_error (cleared only by reset) and return to IDLE.
REQ-025 Without MEM_ARB_TIMEOUT_EN, SHALL wait in WAIT_DATA indefinitely, with timeout_error tied 0 and no counter logic.

Structure
REQ-026 The FSM state encodings and `DEFAULT_MEM_TIMEOUT SHALL live in the shared constants.v, alongside the existing width defaults.
REQ-027 Winner selection SHALL be a sub-module rr_select (inputs req_valid, last_grant; outputs grant_id, any_valid).

Verification
REQ-028 Bench SHALL cover: req_valid=01, read addr 0x40, mem_wait_request=0, mem_read_ready 3 cycles later with 0xBEEF -> mem_read for 1 cycle, rsp_valid=01, rsp_data=0xBEEF.
REQ-029 Bench SHALL cover: req_valid=11 held for 4 transactions -> grants in order 0,1,0,1.
REQ-030 Bench SHALL cover: write from req 1, mem_wait_request high for 5 cycles -> mem_write high for 6 cycles with addr and wdata stable, then rsp_valid=10.
REQ-031 Bench SHALL cover: reset_n pulsed low during WAIT_DATA, then mem_read_ready -> no rsp_valid, FSM in IDLE, all outputs 0.
REQ-032 Bench SHALL cover: with MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, no mem_read_ready -> rsp_valid after 8 WAIT_DATA cycles, rsp_data all-ones, timeout_error=1 until reset.
REQ-033 Bench SHALL cover: mem_read_ready asserted in IDLE -> no rsp_valid and no state change.
